gemm_sched_ctrl: RTL and testbench

//  Sequencer for a single-MAC GEMM datapath computing R = alpha*A*B + beta*C.

---
 rtl/gemm_pkg.sv | 19 +
 rtl/gemm_loop_ctr.sv | 40 ++++
 rtl/gemm_sched_ctrl.sv | 146 ++++++++++++++
 tb/tb_gemm_sched_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM scheduler: FSM state encoding and
// a counter/address width helper that never returns zero.
package gemm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_DRAIN,
        ST_SCALE,
        ST_WRITE,
        ST_DONE
    } gemm_state_e;

    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/gemm_loop_ctr.sv
// Wrap-around loop counter: counts 0..MAX_COUNT-1 on en_i, forced to 0 by clr_i.
// at_max_o flags the final value so counters can be chained.
module gemm_loop_ctr
    import gemm_pkg::*;
#(
    parameter int MAX_COUNT = 4,
    parameter int W         = addr_w(MAX_COUNT)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max_o = (cnt_q == W'(MAX_COUNT - 1));
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_max_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gemm_sched_ctrl.sv
// Sequencer for a single-MAC GEMM: walks R row-major, streams K operand pairs
// per element, then drains the MAC pipe, scales and writes back each result.
module gemm_sched_ctrl
    import gemm_pkg::*;
#(
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_K      = 32,
    parameter int MAC_LAT       = 2,
    localparam int AW = $clog2(MATRIX_HEIGHT * MATRIX_K),
    localparam int BW = $clog2(MATRIX_K * MATRIX_WIDTH),
    localparam int CW = $clog2(MATRIX_HEIGHT * MATRIX_WIDTH)
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          istart,
    input  logic          istall,
    input  logic          iwr_ready,
    output logic [AW-1:0] oa_addr,
    output logic [BW-1:0] ob_addr,
    output logic [CW-1:0] oc_addr,
    output logic          omac_clr,
    output logic          omac_en,
    output logic          oscale_en,
    output logic          owr_en,
    output logic          obusy,
    output logic          odone
);

    localparam int KW  = addr_w(MATRIX_K);
    localparam int CLW = addr_w(MATRIX_WIDTH);
    localparam int RW  = addr_w(MATRIX_HEIGHT);
    localparam int DW  = addr_w(MAC_LAT);

    gemm_state_e state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;

    logic [KW-1:0]  k_cnt;
    logic [CLW-1:0] col_cnt;
    logic [RW-1:0]  row_cnt;
    logic           k_at_max, col_at_max, row_at_max;
    logic           k_en, k_clr, wr_hs, idx_clr;

    // Handshake: owr_en is valid, iwr_ready is ready; a transfer happens
    // in any cycle where both are high, and owr_en never drops before it.
    assign wr_hs   = (state_q == ST_WRITE) && iwr_ready;
    assign k_en    = (state_q == ST_MAC) && !istall;
    assign k_clr   = (state_q == ST_CLEAR);
    assign idx_clr = (state_q == ST_DONE);

    gemm_loop_ctr #(.MAX_COUNT(MATRIX_K), .W(KW)) u_k_ctr (
        .clk_i    (iclk),
        .rst_ni   (irst),
        .en_i     (k_en),
        .clr_i    (k_clr),
        .cnt_o    (k_cnt),
        .at_max_o (k_at_max)
    );

    gemm_loop_ctr #(.MAX_COUNT(MATRIX_WIDTH), .W(CLW)) u_col_ctr (
        .clk_i    (iclk),
        .rst_ni   (irst),
        .en_i     (wr_hs),
        .clr_i    (idx_clr),
        .cnt_o    (col_cnt),
        .at_max_o (col_at_max)
    );

    gemm_loop_ctr #(.MAX_COUNT(MATRIX_HEIGHT), .W(RW)) u_row_ctr (
        .clk_i    (iclk),
        .rst_ni   (irst),
        .en_i     (wr_hs && col_at_max),
        .clr_i    (idx_clr),
        .cnt_o    (row_cnt),
        .at_max_o (row_at_max)
    );

    assign oa_addr = AW'(row_cnt) * AW'(MATRIX_K) + AW'(k_cnt);
    assign ob_addr = BW'(k_cnt) * BW'(MATRIX_WIDTH) + BW'(col_cnt);
    assign oc_addr = CW'(row_cnt) * CW'(MATRIX_WIDTH) + CW'(col_cnt);

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        omac_clr  = 1'b0;
        omac_en   = 1'b0;
        oscale_en = 1'b0;
        owr_en    = 1'b0;
        obusy     = 1'b0;
        odone     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (istart) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                obusy    = 1'b1;
                omac_clr = 1'b1;
                state_d  = ST_MAC;
            end
            ST_MAC: begin
                obusy   = 1'b1;
                omac_en = !istall;
                if (k_at_max && !istall) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(MAC_LAT - 1);
                end
            end
            ST_DRAIN: begin
                obusy = 1'b1;
                if (drain_q == '0) begin
                    state_d = ST_SCALE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_SCALE: begin
                obusy     = 1'b1;
                oscale_en = 1'b1;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                obusy  = 1'b1;
                owr_en = 1'b1;
                if (iwr_ready) begin
                    state_d = (row_at_max && col_at_max) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_DONE: begin
                odone   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_gemm_sched_ctrl.sv
// Directed bench for gemm_sched_ctrl at M=N=4, K=32, MAC_LAT=2: full runs,
// operand stall, writeback backpressure, mid-run reset and ignored restarts.
module tb_gemm_sched_ctrl;

  logic       iclk = 1'b0;
  logic       irst;
  logic       istart;
  logic       istall;
  logic       iwr_ready;
  logic [6:0] oa_addr;
  logic [6:0] ob_addr;
  logic [3:0] oc_addr;
  logic       omac_clr;
  logic       omac_en;
  logic       oscale_en;
  logic       owr_en;
  logic       obusy;
  logic       odone;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state, sampled on the falling edge
  logic [3:0] wr_q[$];
  logic [3:0] exp_q[$];
  int mac_cnt = 0;
  int done_cnt = 0;
  int both_hi = 0;

  gemm_sched_ctrl #(
    .MATRIX_HEIGHT(4),
    .MATRIX_WIDTH (4),
    .MATRIX_K     (32),
    .MAC_LAT      (2)
  ) dut (
    .iclk     (iclk),
    .irst     (irst),
    .istart   (istart),
    .istall   (istall),
    .iwr_ready(iwr_ready),
    .oa_addr  (oa_addr),
    .ob_addr  (ob_addr),
    .oc_addr  (oc_addr),
    .omac_clr (omac_clr),
    .omac_en  (omac_en),
    .oscale_en(oscale_en),
    .owr_en   (owr_en),
    .obusy    (obusy),
    .odone    (odone)
  );

  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (owr_en && iwr_ready) wr_q.push_back(oc_addr);
    if (omac_en) mac_cnt++;
    if (odone) done_cnt++;
    if (odone && obusy) both_hi++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #2;
  endtask

  task automatic start_run();
    istart = 1'b1;
    step();
    istart = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'(oa_addr), 0);
    check({tag, "_b"}, 32'(ob_addr), 0);
    check({tag, "_c"}, 32'(oc_addr), 0);
    check({tag, "_clr"}, 32'(omac_clr), 0);
    check({tag, "_en"}, 32'(omac_en), 0);
    check({tag, "_scale"}, 32'(oscale_en), 0);
    check({tag, "_wr"}, 32'(owr_en), 0);
    check({tag, "_busy"}, 32'(obusy), 0);
    check({tag, "_done"}, 32'(odone), 0);
  endtask

  initial begin
    int n;
    int s_wr;
    int s_mac;
    int s_done;
    int found;

    irst = 1'b0;
    istart = 1'b1;
    istall = 1'b0;
    iwr_ready = 1'b1;
    repeat (3) @(posedge iclk);
    #2;
    check_all_zero("reset");
    istart = 1'b0;
    irst = 1'b1;
    step();
    check("idle_busy", 32'(obusy), 0);

    // Test 1: unstalled full run
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    s_wr = wr_q.size();
    s_mac = mac_cnt;
    s_done = done_cnt;
    start_run();
    check("t1_clear", 32'(omac_clr), 1);
    check("t1_busy", 32'(obusy), 1);
    check("t1_c0", 32'(oc_addr), 0);
    n = 1;
    while (!odone && n < 2000) begin
      step();
      n++;
    end
    check("t1_done_lat", n, 593);
    check("t1_done_busy", 32'(obusy), 0);
    check("t1_writes", wr_q.size() - s_wr, 16);
    check("t1_macs", mac_cnt - s_mac, 512);
    for (int i = 0; i < 16; i++) check("t1_wr_addr", 32'(wr_q[s_wr + i]), 32'(exp_q[i]));
    step();
    check("t1_done_pulse", 32'(odone), 0);
    check("t1_idle_busy", 32'(obusy), 0);
    check("t1_done_cnt", done_cnt - s_done, 1);

    // Test 2: 5-cycle stall mid-MAC of element 0
    s_wr = wr_q.size();
    s_mac = mac_cnt;
    s_done = done_cnt;
    start_run();
    n = 1;
    step();
    n++;
    check("t2_k0_en", 32'(omac_en), 1);
    check("t2_k0_a", 32'(oa_addr), 0);
    repeat (10) begin
      step();
      n++;
    end
    check("t2_k10_a", 32'(oa_addr), 10);
    istall = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      check("t2_stall_en", 32'(omac_en), 0);
      check("t2_stall_a", 32'(oa_addr), 10);
      check("t2_stall_b", 32'(ob_addr), 40);
      step();
      n++;
    end
    istall = 1'b0;
    #1;
    check("t2_resume_en", 32'(omac_en), 1);
    check("t2_resume_a", 32'(oa_addr), 10);
    while (!owr_en && n < 200) begin
      step();
      n++;
    end
    check("t2_elem_cycles", n, 42);
    check("t2_wr_c", 32'(oc_addr), 0);
    check("t2_macs", mac_cnt - s_mac, 32);
    step();
    check("t2_next_clr", 32'(omac_clr), 1);
    check("t2_next_c", 32'(oc_addr), 1);

    // Test 6: element 1 operand addresses
    step();
    for (int j = 0; j < 32; j++) begin
      check("t6_en", 32'(omac_en), 1);
      check("t6_a", 32'(oa_addr), j);
      check("t6_b", 32'(ob_addr), 4 * j + 1);
      step();
    end
    check("t6_drain_en", 32'(omac_en), 0);

    // Test 3: writeback backpressure at element 5
    found = 0;
    for (int j = 0; j < 1000 && found == 0; j++) begin
      if (omac_clr && oc_addr == 4'd5) found = 1;
      else step();
    end
    check("t3_reach_e5", found, 1);
    iwr_ready = 1'b0;
    n = 0;
    while (!owr_en && n < 100) begin
      step();
      n++;
    end
    check("t3_scale_to_wr", n, 36);
    for (int j = 0; j < 3; j++) begin
      check("t3_hold_wr", 32'(owr_en), 1);
      check("t3_hold_c", 32'(oc_addr), 5);
      step();
    end
    iwr_ready = 1'b1;
    check("t3_hs_wr", 32'(owr_en), 1);
    check("t3_hs_c", 32'(oc_addr), 5);
    step();
    check("t3_next_clr", 32'(omac_clr), 1);
    check("t3_next_c", 32'(oc_addr), 6);
    check("t3_next_wr", 32'(owr_en), 0);

    // Test 4: reset during element 9 MAC
    found = 0;
    for (int j = 0; j < 1000 && found == 0; j++) begin
      if (omac_clr && oc_addr == 4'd9) found = 1;
      else step();
    end
    check("t4_reach_e9", found, 1);
    repeat (3) step();
    check("t4_in_mac", 32'(omac_en), 1);
    irst = 1'b0;
    #1;
    check_all_zero("t4_async");
    repeat (3) begin
      step();
      check("t4_held_busy", 32'(obusy), 0);
      check("t4_held_done", 32'(odone), 0);
    end
    check("t4_no_done", done_cnt - s_done, 0);
    check("t4_writes", wr_q.size() - s_wr, 9);
    for (int i = 0; i < 9; i++) check("t4_wr_addr", 32'(wr_q[s_wr + i]), 32'(exp_q[i]));
    irst = 1'b1;
    step();

    // Test 5: istart pulses while busy and in DONE are ignored
    s_wr = wr_q.size();
    s_done = done_cnt;
    start_run();
    check("t5_restart_c", 32'(oc_addr), 0);
    check("t5_restart_clr", 32'(omac_clr), 1);
    n = 1;
    while (!odone && n < 2000) begin
      step();
      n++;
      istart = (n == 100 || n == 300 || n == 400);
    end
    check("t5_done_lat", n, 593);
    istart = 1'b1;
    step();
    istart = 1'b0;
    check("t5_idle_busy", 32'(obusy), 0);
    check("t5_idle_done", 32'(odone), 0);
    step();
    check("t5_no_restart", 32'(obusy), 0);
    step();
    check("t5_done_cnt", done_cnt - s_done, 1);
    check("t5_writes", wr_q.size() - s_wr, 16);
    for (int i = 0; i < 16; i++) check("t5_wr_addr", 32'(wr_q[s_wr + i]), 32'(exp_q[i]));
    check("done_busy_overlap", both_hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
